reg_write_arbiter: RTL and testbench

Sequencer and arbiter for the register bank's single write port. After reset it zero-fills every register through the write port, then shares that port between two writeback requesters (req0: ALU writeback, req1: load writeback) using a valid/ready handshake and round-robin priority. It drives `writeReg`, `writeData` and `regWrite` of the register bank from registered outputs. It enforces that register 0 is never written.

---
 rtl/reg_write_arbiter_if.sv | 44 ++++
 rtl/reg_write_arbiter.sv | 112 +++++++++++
 tb/tb_reg_write_arbiter.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_if.sv
// Register-bank write-port bundle.
// Groups the two writeback requesters (valid/addr/data in, ready out) and the
// registered bank write port (writeReg/writeData/regWrite) plus the grant and
// init status. The arbiter connects through the slave modport; the requesters
// and the bank sit on the master side.
//
// Handshake: a requester raises reqN_valid with reqN_addr/reqN_data and holds
// them stable until reqN_ready is high. A transfer happens on a rising clk
// edge where valid & ready are both 1. Dropping valid before ready withdraws
// the request. Ready is combinational and may depend on valid.
interface reg_write_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) ();
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;

  logic [ADDR_W-1:0] writeReg;
  logic [DATA_W-1:0] writeData;
  logic              regWrite;
  logic              grant_id;
  logic              init_done;

  modport slave (
    input  req0_valid, req0_addr, req0_data,
    input  req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready,
    output writeReg, writeData, regWrite, grant_id, init_done
  );

  modport master (
    output req0_valid, req0_addr, req0_data,
    output req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready,
    input  writeReg, writeData, regWrite, grant_id, init_done
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Write-port sequencer/arbiter for the register bank.
// After reset it optionally zero-fills all 2^ADDR_W registers, then shares
// the single write port between req0 (ALU writeback) and req1 (load
// writeback) with round-robin priority. Register 0 is never written: an
// accepted request to address 0 is consumed but regWrite stays low.
//
// Ports:
//   clk        - clock, rising edge
//   rst        - synchronous active-high reset
//   bus        - reg_write_arbiter_if.slave: requester handshakes and the
//                registered bank write port, grant_id, init_done
//   state_dbg  - current FSM state (0 = CLEAR, 1 = RUN)
module reg_write_arbiter #(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 5,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  reg_write_arbiter_if.slave    bus,
  output logic                  state_dbg
);

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              last_grant;

  logic [ADDR_W-1:0] write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic              reg_write_q;
  logic              grant_id_q;
  logic              init_done_q;

  logic pick0;
  logic pick1;
  logic accept0;
  logic accept1;

  // req1 wins when it is the only one asking, or when both ask and req0 had
  // the previous grant. Readys are gated by valid so a ready always means a
  // transfer this cycle.
  always_comb begin
    pick1   = bus.req1_valid & (~bus.req0_valid | ~last_grant);
    pick0   = bus.req0_valid & ~pick1;
    accept0 = (state == RUN) & pick0;
    accept1 = (state == RUN) & pick1;
  end

  assign bus.req0_ready = accept0;
  assign bus.req1_ready = accept1;

  assign bus.writeReg   = write_reg_q;
  assign bus.writeData  = write_data_q;
  assign bus.regWrite   = reg_write_q;
  assign bus.grant_id   = grant_id_q;
  assign bus.init_done  = init_done_q;
  assign state_dbg      = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt      <= '0;
      last_grant   <= 1'b1;
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
      grant_id_q   <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          reg_write_q  <= 1'b1;
          write_reg_q  <= clr_cnt;
          write_data_q <= '0;
          clr_cnt      <= clr_cnt + 1'b1;
          if (&clr_cnt) begin
            state <= RUN;
          end
        end
        RUN: begin
          // Set on the first RUN edge, so init_done rises together with the
          // first possible accept (one cycle after the last clear write).
          init_done_q <= 1'b1;
          if (accept0) begin
            write_reg_q  <= bus.req0_addr;
            write_data_q <= bus.req0_data;
            reg_write_q  <= |bus.req0_addr;
            grant_id_q   <= 1'b0;
            last_grant   <= 1'b0;
          end else if (accept1) begin
            write_reg_q  <= bus.req1_addr;
            write_data_q <= bus.req1_data;
            reg_write_q  <= |bus.req1_addr;
            grant_id_q   <= 1'b1;
            last_grant   <= 1'b1;
          end else begin
            reg_write_q  <= 1'b0;
          end
        end
        default: begin
          state <= CLEAR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed testbench for reg_write_arbiter.
// dut_a runs with the zero-fill enabled, dut_b with it disabled. Inputs are
// driven 1 ns after each rising edge and outputs are sampled there as well.
module tb_reg_write_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_a = 1'b1;
  logic rst_b = 1'b1;
  logic state_a;
  logic state_b;

  always #5 clk = ~clk;

  reg_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_a ();
  reg_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();

  reg_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk       (clk),
    .rst       (rst_a),
    .bus       (bus_a.slave),
    .state_dbg (state_a)
  );

  reg_write_arbiter #(.DATA_W(DW), .ADDR_W(AW), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk       (clk),
    .rst       (rst_b),
    .bus       (bus_b.slave),
    .state_dbg (state_b)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  // expected write: {grant_id, addr, data}
  logic [AW+DW:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
    bus_a.req0_valid = v0;
    bus_a.req0_addr  = a0;
    bus_a.req0_data  = d0;
    bus_a.req1_valid = v1;
    bus_a.req1_addr  = a1;
    bus_a.req1_data  = d1;
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, " regWrite"},  64'(bus_a.regWrite), 64'd0);
    check({tag, " writeReg"},  64'(bus_a.writeReg), 64'd0);
    check({tag, " writeData"}, 64'(bus_a.writeData), 64'd0);
    check({tag, " grant_id"},  64'(bus_a.grant_id), 64'd0);
    check({tag, " init_done"}, 64'(bus_a.init_done), 64'd0);
  endtask

  // Releases rst_a and follows the whole zero-fill. req0 stays valid while
  // the clear runs to show readys are held low, then withdraws before RUN.
  task automatic clear_seq(input string tag);
    drive_a(1'b1, 5'd9, 32'h1, 1'b1, 5'd10, 32'h2);
    rst_a = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      check({tag, " clr regWrite"},  64'(bus_a.regWrite), 64'd1);
      check({tag, " clr writeReg"},  64'(bus_a.writeReg), 64'(i));
      check({tag, " clr writeData"}, 64'(bus_a.writeData), 64'd0);
      check({tag, " clr init_done"}, 64'(bus_a.init_done), 64'd0);
      if (i < DEPTH - 1) begin
        check({tag, " clr ready0"}, 64'(bus_a.req0_ready), 64'd0);
        check({tag, " clr ready1"}, 64'(bus_a.req1_ready), 64'd0);
      end
      if (i == DEPTH - 2) drive_a(1'b0, '0, '0, 1'b0, '0, '0);
    end
    tick();
    check({tag, " post init_done"}, 64'(bus_a.init_done), 64'd1);
    check({tag, " post regWrite"},  64'(bus_a.regWrite), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW+DW:0] e;
    logic [AW-1:0] ca [2];
    logic [DW-1:0] cd [2];
    ca[0] = 5'd1; cd[0] = 32'h11;
    ca[1] = 5'd2; cd[1] = 32'h22;

    drive_a(1'b0, '0, '0, 1'b0, '0, '0);
    bus_b.req0_valid = 1'b0; bus_b.req0_addr = '0; bus_b.req0_data = '0;
    bus_b.req1_valid = 1'b0; bus_b.req1_addr = '0; bus_b.req1_data = '0;

    // reset values
    repeat (3) tick();
    check_reset_outs("reset");
    check("reset state", 64'(state_a), 64'd0);

    // reset in clear cycle 10
    rst_a = 1'b0;
    repeat (10) tick();
    check("midclr writeReg", 64'(bus_a.writeReg), 64'd9);
    rst_a = 1'b1;
    tick();
    check_reset_outs("midclr");

    // full clear after release
    clear_seq("full");

    // conflict: both valid, grants 0,1,0,1 with no idle cycle
    drive_a(1'b1, ca[0], cd[0], 1'b1, ca[1], cd[1]);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("conf ready0", 64'(bus_a.req0_ready), 64'((k % 2) == 0));
      check("conf ready1", 64'(bus_a.req1_ready), 64'((k % 2) == 1));
      exp_q.push_back({1'(k % 2), ca[k % 2], cd[k % 2]});
      tick();
      if (k == 3) drive_a(1'b0, '0, '0, 1'b0, '0, '0);
      e = exp_q.pop_front();
      check("conf regWrite",  64'(bus_a.regWrite), 64'd1);
      check("conf grant_id",  64'(bus_a.grant_id), 64'(e[AW+DW]));
      check("conf writeReg",  64'(bus_a.writeReg), 64'(e[AW+DW-1:DW]));
      check("conf writeData", 64'(bus_a.writeData), 64'(e[DW-1:0]));
    end
    tick();
    check("conf idle regWrite", 64'(bus_a.regWrite), 64'd0);

    // single requester
    drive_a(1'b1, 5'd7, 32'hDEADBEEF, 1'b0, '0, '0);
    #1;
    check("single ready0", 64'(bus_a.req0_ready), 64'd1);
    check("single ready1", 64'(bus_a.req1_ready), 64'd0);
    tick();
    drive_a(1'b0, '0, '0, 1'b0, '0, '0);
    check("single regWrite",  64'(bus_a.regWrite), 64'd1);
    check("single writeReg",  64'(bus_a.writeReg), 64'd7);
    check("single writeData", 64'(bus_a.writeData), 64'hDEADBEEF);
    check("single grant_id",  64'(bus_a.grant_id), 64'd0);
    tick();
    check("hold regWrite",  64'(bus_a.regWrite), 64'd0);
    check("hold writeReg",  64'(bus_a.writeReg), 64'd7);
    check("hold writeData", 64'(bus_a.writeData), 64'hDEADBEEF);

    // register 0 protection
    drive_a(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF);
    #1;
    check("r0 ready1", 64'(bus_a.req1_ready), 64'd1);
    tick();
    drive_a(1'b0, '0, '0, 1'b0, '0, '0);
    check("r0 regWrite", 64'(bus_a.regWrite), 64'd0);
    check("r0 grant_id", 64'(bus_a.grant_id), 64'd1);
    check("r0 writeReg", 64'(bus_a.writeReg), 64'd0);

    // reset mid-RUN discards the accept on that edge
    drive_a(1'b1, 5'd4, 32'h44, 1'b0, '0, '0);
    rst_a = 1'b1;
    tick();
    drive_a(1'b0, '0, '0, 1'b0, '0, '0);
    check_reset_outs("midrun");

    // clear disabled: first edge after reset accepts
    check("nclr init rst", 64'(bus_b.init_done), 64'd0);
    bus_b.req0_valid = 1'b1; bus_b.req0_addr = 5'd3; bus_b.req0_data = 32'd5;
    rst_b = 1'b0;
    #1;
    check("nclr ready0", 64'(bus_b.req0_ready), 64'd1);
    tick();
    bus_b.req0_valid = 1'b0;
    check("nclr regWrite",  64'(bus_b.regWrite), 64'd1);
    check("nclr writeReg",  64'(bus_b.writeReg), 64'd3);
    check("nclr writeData", 64'(bus_b.writeData), 64'd5);
    check("nclr init_done", 64'(bus_b.init_done), 64'd1);

    // ---------------- report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
